text_msg_ctrl: RTL and testbench
================================

// Module: text_msg_ctrl
// PURPOSE
//  Sequences on-screen text messages ("ROUND n", "GAME OVER", "PERFECT", "GO!") for the char overlay drawer.
//  Accepts a message request, runs a frame-timed BLINK then HOLD schedule, drives the drawer's enable,
//  and serves per-glyph char codes / font ROM addresses from the drawer's char_xy/char_line.
//  Sits between game FSM (requester) and draw path (drawer + external 1-cycle synchronous font ROM).
// PARAMETERS
//  WIDTH        16   message field length in chars; char_xy >= WIDTH renders space
//  BLINK_FRAMES 16   frames per blink half-period (>=1)
//  BLINK_COUNT  3    number of off/on blink pairs before HOLD (0 = skip BLINK)
//  HOLD_FRAMES  120  frames of steady display in HOLD (>=1)
// PORTS
//  clk        in   1   system/pixel clock
//  rst        in   1   asynchronous, active-high reset
//  vsync      in   1   VGA vsync; rising edge = frame tick
//  req_valid  in   1   message request valid
//  req_ready  out  1   controller can accept request (comb: state==IDLE && !cancel)
//  req_msg    in   2   message id: 0 ROUND n, 1 GAME OVER, 2 PERFECT, 3 GO!
//  round_num  in   4   digit for msg 0, latched on accept
//  cancel     in   1   abort current message
//  char_xy    in   8   char column from drawer
//  char_line  in   4   glyph row from drawer
//  char_code  out  7   ASCII code of current column
//  font_addr  out  11  {char_code, char_line} to font ROM
//  enable     out  1   drawer enable
//  busy       out  1   state != IDLE
//  done       out  1   one-cycle pulse at normal completion
// BEHAVIOUR
//  Reset (async, any state): state IDLE, enable 0, done 0, busy 0, char_code 7'h20, font_addr {7'h20,4'h0},
//   counters 0, vsync_prev 0, latched msg/round 0. Reset mid-message drops it with no done pulse.
//  Frame tick: vsync & ~vsync_prev, vsync_prev registered every cycle.
//  Handshake: accept when req_valid && req_ready; latch req_msg/round_num; next cycle state BLINK (or HOLD
//   if BLINK_COUNT==0), enable 1, frame_cnt 0, toggle_cnt 0. Requests outside IDLE are ignored (not queued).
//  BLINK: on tick frame_cnt++; at tick with frame_cnt==BLINK_FRAMES-1: enable toggles, frame_cnt 0,
//   toggle_cnt++; after toggle 2*BLINK_COUNT (enable back to 1) -> HOLD, frame_cnt 0.
//  HOLD: enable 1; on tick frame_cnt++; at tick with frame_cnt==HOLD_FRAMES-1 -> DONE.
//  DONE: one cycle; enable 0, done 1 -> IDLE. IDLE: enable 0.
//  cancel in any non-IDLE state: next cycle IDLE, enable 0, no done. cancel with req_valid in IDLE:
//   cancel wins, request not accepted (req_ready 0 that cycle).
//  Glyph path: char_code registered, 1-cycle latency from char_xy; font_addr = {char_code, char_line_d1}
//   (char_line delayed 1 cycle to align). With 1-cycle ROM, pixels arrive 2 cycles after char_xy,
//   matching drawer stage III sampling. Glyph path runs in every state (enable gates drawing).
//  Messages left-aligned, padded with 7'h20: msg0 "ROUND d" (d='0'+round_num, round_num>9 -> '?'),
//   msg1 "GAME OVER", msg2 "PERFECT", msg3 "GO!". char_xy >= WIDTH -> 7'h20.
//  Counters sized $clog2(max(BLINK_FRAMES,HOLD_FRAMES)+1) and $clog2(2*BLINK_COUNT+1); no wrap possible.
// TESTING (sim params BLINK_FRAMES=2, BLINK_COUNT=1, HOLD_FRAMES=3)
//  1 Reset: assert rst mid-HOLD -> enable 0, busy 0, char_code 7'h20 immediately; no done pulse.
//  2 Full run: req msg1 in IDLE -> enable 1; off after tick 2, on after tick 4, HOLD;
//     done pulse 1 cycle after tick 7; enable 0; req_ready 1 next cycle.
//  3 Glyph: msg0 round_num 7, char_xy 0..7 -> char_code 'R','O','U','N','D',' ','7',' ' one cycle later;
//     char_xy 20 -> 7'h20; round_num 12 -> '?'; char_line 5 -> font_addr[3:0]==5 aligned.
//  4 Handshake: req_valid held during BLINK -> req_ready 0, not accepted; accepted only after done.
//  5 Cancel: cancel during BLINK -> IDLE next cycle, enable 0, no done; cancel+req_valid in IDLE -> not accepted.
//  6 vsync held high many cycles -> single tick; BLINK_COUNT=0 build -> accept goes straight to HOLD.

Source files
------------

// File: rtl/text_msg_ctrl.sv
// text_msg_ctrl: sequences on-screen text messages with a frame-timed BLINK/HOLD
// schedule, drives the char overlay drawer enable and serves glyph char codes and
// font ROM addresses for the drawer's current column and glyph row.
module text_msg_ctrl #(
  parameter int WIDTH        = 16,
  parameter int BLINK_FRAMES = 16,
  parameter int BLINK_COUNT  = 3,
  parameter int HOLD_FRAMES  = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_msg,
  input  logic [3:0]  round_num,
  input  logic        cancel,
  input  logic [7:0]  char_xy,
  input  logic [3:0]  char_line,
  output logic [6:0]  char_code,
  output logic [10:0] font_addr,
  output logic        enable,
  output logic        busy,
  output logic        done
);

  localparam int FRAME_MAX = (BLINK_FRAMES > HOLD_FRAMES) ? BLINK_FRAMES : HOLD_FRAMES;
  localparam int FC_W      = $clog2(FRAME_MAX + 1);
  localparam int TC_W      = (BLINK_COUNT > 0) ? $clog2(2 * BLINK_COUNT + 1) : 1;

  localparam logic [FC_W-1:0] BLINK_LAST  = FC_W'(BLINK_FRAMES - 1);
  localparam logic [FC_W-1:0] HOLD_LAST   = FC_W'(HOLD_FRAMES - 1);
  localparam logic [FC_W-1:0] FC_ONE      = FC_W'(1);
  localparam logic [TC_W-1:0] TOGGLE_LAST = TC_W'((BLINK_COUNT > 0) ? 2 * BLINK_COUNT - 1 : 0);
  localparam logic [TC_W-1:0] TC_ONE      = TC_W'(1);
  localparam logic [8:0]      WIDTH_LIM   = (WIDTH > 256) ? 9'd256 : 9'(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLINK = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  // With no blink pairs configured, an accepted message goes straight to steady display
  localparam logic [1:0] S_START = (BLINK_COUNT > 0) ? S_BLINK : S_HOLD;

  logic [1:0]      state;
  logic [FC_W-1:0] frame_cnt;
  logic [TC_W-1:0] toggle_cnt;
  logic            vsync_prev;
  logic            tick;
  logic [1:0]      msg_lat;
  logic [3:0]      round_lat;
  logic [6:0]      digit;
  logic [6:0]      glyph;
  logic [3:0]      line_d1;

  function automatic logic [6:0] asc(input logic [7:0] c);
    return c[6:0];
  endfunction

  assign tick      = vsync & ~vsync_prev;
  assign req_ready = (state == S_IDLE) && !cancel;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign font_addr = {char_code, line_d1};

  // Remember last vsync level so a long vsync pulse yields exactly one frame tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_prev <= 1'b0;
    end else begin
      vsync_prev <= vsync;
    end
  end

  // Message schedule: accept a request, blink by frame count, hold, then complete or cancel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      enable     <= 1'b0;
      frame_cnt  <= '0;
      toggle_cnt <= '0;
      msg_lat    <= 2'd0;
      round_lat  <= 4'd0;
    end else if (state != S_IDLE && cancel) begin
      state      <= S_IDLE;
      enable     <= 1'b0;
      frame_cnt  <= '0;
      toggle_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          enable <= 1'b0;
          if (req_valid && req_ready) begin
            msg_lat    <= req_msg;
            round_lat  <= round_num;
            state      <= S_START;
            enable     <= 1'b1;
            frame_cnt  <= '0;
            toggle_cnt <= '0;
          end
        end
        S_BLINK: begin
          if (tick) begin
            if (frame_cnt == BLINK_LAST) begin
              enable     <= ~enable;
              frame_cnt  <= '0;
              toggle_cnt <= toggle_cnt + TC_ONE;
              if (toggle_cnt == TOGGLE_LAST) begin
                state <= S_HOLD;
              end
            end else begin
              frame_cnt <= frame_cnt + FC_ONE;
            end
          end
        end
        S_HOLD: begin
          enable <= 1'b1;
          if (tick) begin
            if (frame_cnt == HOLD_LAST) begin
              state     <= S_DONE;
              enable    <= 1'b0;
              frame_cnt <= '0;
            end else begin
              frame_cnt <= frame_cnt + FC_ONE;
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          enable <= 1'b0;
        end
      endcase
    end
  end

  // Character lookup for the current column of the latched message, space padded
  always_comb begin
    digit = (round_lat > 4'd9) ? asc("?") : (7'h30 + {3'b000, round_lat});
    glyph = 7'h20;
    if ({1'b0, char_xy} < WIDTH_LIM) begin
      case (msg_lat)
        2'd0: begin
          case (char_xy)
            8'd0:    glyph = asc("R");
            8'd1:    glyph = asc("O");
            8'd2:    glyph = asc("U");
            8'd3:    glyph = asc("N");
            8'd4:    glyph = asc("D");
            8'd6:    glyph = digit;
            default: glyph = 7'h20;
          endcase
        end
        2'd1: begin
          case (char_xy)
            8'd0:    glyph = asc("G");
            8'd1:    glyph = asc("A");
            8'd2:    glyph = asc("M");
            8'd3:    glyph = asc("E");
            8'd5:    glyph = asc("O");
            8'd6:    glyph = asc("V");
            8'd7:    glyph = asc("E");
            8'd8:    glyph = asc("R");
            default: glyph = 7'h20;
          endcase
        end
        2'd2: begin
          case (char_xy)
            8'd0:    glyph = asc("P");
            8'd1:    glyph = asc("E");
            8'd2:    glyph = asc("R");
            8'd3:    glyph = asc("F");
            8'd4:    glyph = asc("E");
            8'd5:    glyph = asc("C");
            8'd6:    glyph = asc("T");
            default: glyph = 7'h20;
          endcase
        end
        default: begin
          case (char_xy)
            8'd0:    glyph = asc("G");
            8'd1:    glyph = asc("O");
            8'd2:    glyph = asc("!");
            default: glyph = 7'h20;
          endcase
        end
      endcase
    end
  end

  // Register char code and delay glyph row by one cycle so the ROM address stays aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_code <= 7'h20;
      line_d1   <= 4'h0;
    end else begin
      char_code <= glyph;
      line_d1   <= char_line;
    end
  end

endmodule

// File: tb/tb_text_msg_ctrl.sv
// tb_text_msg_ctrl: directed and randomized checks of text_msg_ctrl against a
// frame-count reference model, with a second instance built without blink pairs.
module tb_text_msg_ctrl;

  localparam int WIDTH = 16;
  localparam int BF    = 2;
  localparam int BC    = 1;
  localparam int HF    = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync;
  logic        req_valid;
  logic        req_valid_b;
  logic [1:0]  req_msg;
  logic [3:0]  round_num;
  logic        cancel;
  logic [7:0]  char_xy;
  logic [3:0]  char_line;

  logic        req_ready, enable, busy, done;
  logic [6:0]  char_code;
  logic [10:0] font_addr;
  logic        req_ready_b, enable_b, busy_b, done_b;
  logic [6:0]  char_code_b;
  logic [10:0] font_addr_b;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  int ticks_a = 0;
  int ticks_b = 0;
  bit run_a = 1'b0;
  bit run_b = 1'b0;
  bit held_a = 1'b0;
  int cur_msg = 0;
  int cur_round = 0;
  int msg_b = 0;
  int round_b = 0;

  text_msg_ctrl #(.WIDTH(WIDTH), .BLINK_FRAMES(BF), .BLINK_COUNT(BC), .HOLD_FRAMES(HF)) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .req_valid(req_valid), .req_ready(req_ready),
    .req_msg(req_msg), .round_num(round_num), .cancel(cancel), .char_xy(char_xy),
    .char_line(char_line), .char_code(char_code), .font_addr(font_addr),
    .enable(enable), .busy(busy), .done(done)
  );

  text_msg_ctrl #(.WIDTH(WIDTH), .BLINK_FRAMES(BF), .BLINK_COUNT(0), .HOLD_FRAMES(HF)) dut_b (
    .clk(clk), .rst(rst), .vsync(vsync), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_msg(req_msg), .round_num(round_num), .cancel(cancel), .char_xy(char_xy),
    .char_line(char_line), .char_code(char_code_b), .font_addr(font_addr_b),
    .enable(enable_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  // Count completion pulses of the main instance, sampled just after each clock edge
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_cnt++;
  end

  // Safety net so the run always ends even if the schedule stalls
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int total_ticks(int bc);
    return 2 * bc * BF + HF;
  endfunction

  function automatic logic exp_en(int t, int bc);
    if (t >= total_ticks(bc)) return 1'b0;
    if (t < 2 * bc * BF) return ((t / BF) % 2) == 0;
    return 1'b1;
  endfunction

  function automatic logic [6:0] exp_char(int msg, int rnd, int xy);
    string s;
    string d;
    byte   b;
    if (rnd > 9) d = "?";
    else d = $sformatf("%0d", rnd);
    case (msg)
      0: s = {"ROUND ", d};
      1: s = "GAME OVER";
      2: s = "PERFECT";
      default: s = "GO!";
    endcase
    if (xy >= WIDTH || xy >= s.len()) return 7'h20;
    b = s[xy];
    return b[6:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    checkOutput("enable_a", {31'b0, enable}, {31'b0, run_a ? exp_en(ticks_a, BC) : 1'b0});
    checkOutput("busy_a", {31'b0, busy}, {31'b0, run_a});
    checkOutput("enable_b", {31'b0, enable_b}, {31'b0, run_b ? exp_en(ticks_b, 0) : 1'b0});
    checkOutput("busy_b", {31'b0, busy_b}, {31'b0, run_b});
  endtask

  task automatic applyStimulus(input int hi, input int lo);
    bit fin_a;
    bit fin_b;
    vsync = 1'b1;
    @(negedge clk);
    if (run_a) ticks_a++;
    if (run_b) ticks_b++;
    fin_a = run_a && (ticks_a == total_ticks(BC));
    fin_b = run_b && (ticks_b == total_ticks(0));
    checkOutput("done_a", {31'b0, done}, {31'b0, fin_a});
    checkOutput("done_b", {31'b0, done_b}, {31'b0, fin_b});
    if (fin_a) checkOutput("enable_at_done_a", {31'b0, enable}, 32'd0);
    @(negedge clk);
    checkOutput("done_width_a", {31'b0, done}, 32'd0);
    checkOutput("done_width_b", {31'b0, done_b}, 32'd0);
    if (fin_a) begin
      checkOutput("ready_after_done_a", {31'b0, req_ready}, 32'd1);
      if (held_a) begin
        ticks_a   = 0;
        cur_msg   = req_msg;
        cur_round = round_num;
      end else begin
        run_a = 1'b0;
      end
    end
    if (fin_b) begin
      checkOutput("ready_after_done_b", {31'b0, req_ready_b}, 32'd1);
      run_b = 1'b0;
    end
    repeat (hi - 2) @(negedge clk);
    vsync = 1'b0;
    repeat (lo) @(negedge clk);
    check_state();
  endtask

  task automatic accept_a(input int msg, input int rnd);
    req_msg   = 2'(msg);
    round_num = 4'(rnd);
    req_valid = 1'b1;
    #1;
    checkOutput("ready_idle_a", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    run_a     = 1'b1;
    ticks_a   = 0;
    cur_msg   = msg;
    cur_round = rnd;
    check_state();
  endtask

  task automatic cancel_a();
    cancel = 1'b1;
    #1;
    checkOutput("ready_during_cancel", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    cancel = 1'b0;
    run_a  = 1'b0;
    check_state();
  endtask

  task automatic check_glyph(input int xy, input int line);
    logic [6:0] e;
    char_xy   = 8'(xy);
    char_line = 4'(line);
    @(negedge clk);
    e = exp_char(cur_msg, cur_round, xy);
    checkOutput("char_code", {25'b0, char_code}, {25'b0, e});
    checkOutput("font_addr", {21'b0, font_addr}, {21'b0, e, 4'(line)});
  endtask

  initial begin
    int dc;
    rst = 1'b1; vsync = 1'b0; req_valid = 1'b0; req_valid_b = 1'b0;
    req_msg = 2'd0; round_num = 4'd0; cancel = 1'b0; char_xy = 8'd0; char_line = 4'd0;
    #1;
    checkOutput("reset_enable", {31'b0, enable}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_char_code", {25'b0, char_code}, 32'h20);
    checkOutput("reset_font_addr", {21'b0, font_addr}, 32'h200);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_state();

    $display("[TB] full run of GAME OVER");
    dc = done_cnt;
    accept_a(1, $urandom_range(0, 15));
    for (int i = 0; i < total_ticks(BC); i++) applyStimulus($urandom_range(2, 4), $urandom_range(2, 4));
    checkOutput("done_pulses_full_run", done_cnt - dc, 32'd1);

    $display("[TB] reset during HOLD");
    accept_a(2, 0);
    for (int i = 0; i < 2 * BC * BF + 1; i++) applyStimulus(2, 2);
    dc = done_cnt;
    rst = 1'b1;
    #1;
    checkOutput("midrun_reset_enable", {31'b0, enable}, 32'd0);
    checkOutput("midrun_reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("midrun_reset_char_code", {25'b0, char_code}, 32'h20);
    @(negedge clk);
    rst = 1'b0;
    run_a = 1'b0; cur_msg = 0; cur_round = 0;
    repeat (3) @(negedge clk);
    check_state();
    checkOutput("midrun_reset_no_done", done_cnt - dc, 32'd0);

    $display("[TB] glyph path");
    accept_a(0, 7);
    for (int x = 0; x < 8; x++) check_glyph(x, $urandom_range(0, 15));
    check_glyph(20, 5);
    check_glyph(5, 5);
    for (int i = 0; i < 6; i++) check_glyph($urandom_range(0, WIDTH + 8), $urandom_range(0, 15));
    cancel_a();
    accept_a(0, 12);
    check_glyph(6, 3);
    check_glyph(0, 9);

    $display("[TB] cancel behaviour");
    cancel_a();
    accept_a(3, 0);
    applyStimulus(2, 2);
    dc = done_cnt;
    cancel_a();
    repeat (3) @(negedge clk);
    checkOutput("cancel_no_done", done_cnt - dc, 32'd0);
    req_valid = 1'b1;
    cancel = 1'b1;
    #1;
    checkOutput("cancel_beats_request", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    cancel = 1'b0;
    @(negedge clk);
    check_state();

    $display("[TB] request held through a message");
    req_msg = 2'd1;
    round_num = 4'd3;
    req_valid = 1'b1;
    #1;
    checkOutput("held_ready_idle", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    run_a = 1'b1; ticks_a = 0; cur_msg = 1; cur_round = 3; held_a = 1'b1;
    req_msg = 2'd2;
    check_state();
    check_glyph(0, 1);
    applyStimulus(2, 2);
    checkOutput("held_ready_blink", {31'b0, req_ready}, 32'd0);
    check_glyph(1, 2);
    for (int i = 1; i < total_ticks(BC); i++) applyStimulus(2, 3);
    req_valid = 1'b0;
    held_a = 1'b0;
    check_glyph(0, 4);
    cancel_a();

    $display("[TB] long vsync and no-blink build");
    accept_a(0, 4);
    applyStimulus(12, 3);
    applyStimulus(2, 2);
    cancel_a();
    req_msg = 2'd3;
    req_valid_b = 1'b1;
    #1;
    checkOutput("ready_idle_b", {31'b0, req_ready_b}, 32'd1);
    @(negedge clk);
    req_valid_b = 1'b0;
    run_b = 1'b1; ticks_b = 0; msg_b = 3; round_b = 0;
    check_state();
    char_xy = 8'd1;
    char_line = 4'd7;
    @(negedge clk);
    checkOutput("char_code_b", {25'b0, char_code_b}, {25'b0, exp_char(msg_b, round_b, 1)});
    checkOutput("font_addr_b", {21'b0, font_addr_b}, {21'b0, exp_char(msg_b, round_b, 1), 4'd7});
    for (int i = 0; i < total_ticks(0); i++) applyStimulus(2, 2);

    $display("[TB] randomized messages");
    for (int r = 0; r < 4; r++) begin
      accept_a($urandom_range(0, 3), $urandom_range(0, 15));
      for (int g = 0; g < 3; g++) check_glyph($urandom_range(0, WIDTH + 4), $urandom_range(0, 15));
      for (int i = 0; i < total_ticks(BC); i++) applyStimulus($urandom_range(2, 5), $urandom_range(2, 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
